// File: rtl/polygon_vertex_loader_if.sv
// Vertex memory read bus used by polygon_vertex_loader.
// Handshake: rd is a one-cycle request strobe with addr valid in the same
// cycle; the memory answers every request exactly once, in request order,
// at least one cycle later, by raising valid for one cycle with x/y. There
// is no ready/backpressure on either direction: the memory must accept one
// request per cycle and the loader must accept every returned beat.
interface polygon_vertex_loader_if #(
    parameter int WORLD_BITS = 32,
    parameter int ADDR_BITS  = 10
) ();
    logic                         rd;
    logic [ADDR_BITS-1:0]         addr;
    logic                         valid;
    logic signed [WORLD_BITS-1:0] x;
    logic signed [WORLD_BITS-1:0] y;

    modport master (output rd, addr, input valid, x, y);
    modport slave  (input rd, addr, output valid, x, y);
endinterface

// File: rtl/polygon_vertex_loader.sv
// Double-buffered polygon vertex loader. A shadow bank is filled from vertex
// memory during a frame and swapped into the active bank at the next frame
// start, so the point-in-polygon tester sees a bank that is stable all frame.
module polygon_vertex_loader #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    parameter int ADDR_BITS        = 10,
    localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1),
    localparam int IDX_W = $clog2(MAX_NUM_VERTICES)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         new_frame_in,
    input  logic [ADDR_BITS-1:0]         base_addr_in,
    input  logic [CNT_W-1:0]             count_in,
    polygon_vertex_loader_if.master      mem,
    output logic signed [WORLD_BITS-1:0] poly_xs_out [MAX_NUM_VERTICES],
    output logic signed [WORLD_BITS-1:0] poly_ys_out [MAX_NUM_VERTICES],
    output logic [CNT_W-1:0]             num_points_out,
    output logic                         swap_out,
    output logic                         busy_out,
    output logic                         overrun_out,
    output logic [1:0]                   state_out
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_READY} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUM_VERTICES);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(3);

    state_t                       state_q, state_d;
    logic [ADDR_BITS-1:0]         base_q;
    logic [CNT_W-1:0]             n_q;
    logic [CNT_W-1:0]             issue_q;
    logic [CNT_W-1:0]             ret_q;
    logic [CNT_W-1:0]             shadow_cnt_q;
    logic signed [WORLD_BITS-1:0] shadow_xs [MAX_NUM_VERTICES];
    logic signed [WORLD_BITS-1:0] shadow_ys [MAX_NUM_VERTICES];

    logic             loading;
    logic             start;
    logic             ret_hit;
    logic             ret_last;
    logic [CNT_W-1:0] clamped_n;
    logic [CNT_W-1:0] eff_n;

    assign loading   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign busy_out  = loading;
    assign state_out = state_q;

    // Decode frame start, return acceptance, effective count and next state.
    always_comb begin
        start     = new_frame_in && !loading;
        ret_hit   = mem.valid && loading && (ret_q < n_q);
        ret_last  = ret_hit && ((ret_q + CNT_W'(1)) == n_q);
        clamped_n = (count_in > MAX_CNT) ? MAX_CNT : count_in;
        eff_n     = (clamped_n < MIN_CNT) ? '0 : clamped_n;
        state_d   = state_q;
        case (state_q)
            S_IDLE, S_READY: if (new_frame_in) state_d = (eff_n == '0) ? S_READY : S_FETCH;
            S_FETCH: begin
                if (ret_last)                          state_d = S_READY;
                else if (issue_q == n_q - CNT_W'(1))   state_d = S_DRAIN;
            end
            S_DRAIN: if (ret_last) state_d = S_READY;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request issue, shadow fill, bank swap and status pulses.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            base_q         <= '0;
            n_q            <= '0;
            issue_q        <= '0;
            ret_q          <= '0;
            shadow_cnt_q   <= '0;
            num_points_out <= '0;
            swap_out       <= 1'b0;
            overrun_out    <= 1'b0;
            mem.rd         <= 1'b0;
            mem.addr       <= '0;
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                shadow_xs[i]   <= '0;
                shadow_ys[i]   <= '0;
                poly_xs_out[i] <= '0;
                poly_ys_out[i] <= '0;
            end
        end else begin
            swap_out    <= 1'b0;
            overrun_out <= 1'b0;
            mem.rd      <= 1'b0;

            if (start) begin
                // Publish the completed shadow only if a load has finished;
                // from IDLE there is nothing valid to publish yet.
                if (state_q == S_READY) begin
                    poly_xs_out    <= shadow_xs;
                    poly_ys_out    <= shadow_ys;
                    num_points_out <= shadow_cnt_q;
                    swap_out       <= 1'b1;
                end
                base_q       <= base_addr_in;
                n_q          <= eff_n;
                ret_q        <= '0;
                shadow_cnt_q <= '0;
                for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                    shadow_xs[i] <= '0;
                    shadow_ys[i] <= '0;
                end
                // Request 0 goes out on the cycle the state enters FETCH.
                if (eff_n != '0) begin
                    mem.rd   <= 1'b1;
                    mem.addr <= base_addr_in;
                    issue_q  <= CNT_W'(1);
                end else begin
                    issue_q  <= '0;
                end
            end

            // A frame edge during a load is reported; its base/count are dropped.
            if (new_frame_in && loading) overrun_out <= 1'b1;

            // Address wraps naturally at the ADDR_BITS boundary.
            if (state_q == S_FETCH) begin
                mem.rd   <= 1'b1;
                mem.addr <= base_q + ADDR_BITS'(issue_q);
                issue_q  <= issue_q + CNT_W'(1);
            end

            if (ret_hit) begin
                shadow_xs[ret_q[IDX_W-1:0]] <= mem.x;
                shadow_ys[ret_q[IDX_W-1:0]] <= mem.y;
                ret_q <= ret_q + CNT_W'(1);
                if (ret_last) shadow_cnt_q <= n_q;
            end
        end
    end
endmodule
